// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM state encoding,
// owner codes and memory access length codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  localparam logic [2:0] OP_BYTE = 3'd0;
  localparam logic [2:0] OP_HALF = 3'd1;
  localparam logic [2:0] OP_WORD = 3'd2;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Data has priority unless the starvation flag hands the slot to a waiting fetch.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic starve,
  output logic winner
);

  always_comb begin
    winner = OWNER_DATA;
    if (!d_req || (starve && if_req)) winner = OWNER_FETCH;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_address,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_op_length,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_input_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_op_length,
  input  logic [31:0] mem_output_data,
  output logic        busy,
  output logic        owner
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_cfg
    $error("mem_arbiter: READ_LATENCY must be 1..4 and STARVE_LIMIT 1..15");
  end

  // WAIT lasts READ_LATENCY-1 cycles; the counter runs down to zero.
  localparam logic [1:0] WAIT_LOAD = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  arb_state_t state;
  logic [1:0] wait_cnt;
  logic       lat_write;
  logic       starve;
  logic       winner;
  logic       any_req;

  assign any_req = if_req | d_req;

  mem_arbiter_pick u_pick (
    .if_req (if_req),
    .d_req  (d_req),
    .starve (starve),
    .winner (winner)
  );

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign starve = (starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE && any_req) begin
      if (winner == OWNER_FETCH) starve_cnt <= '0;
      else if (if_req)           starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      owner          <= OWNER_FETCH;
      lat_write      <= 1'b0;
      wait_cnt       <= '0;
      mem_address    <= '0;
      mem_input_data <= '0;
      mem_op_length  <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      if_ready       <= 1'b0;
      d_ready        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state <= ST_ISSUE;
            owner <= winner;
            if (winner == OWNER_DATA) begin
              lat_write      <= d_write;
              mem_address    <= d_address;
              mem_input_data <= d_wdata;
              mem_op_length  <= d_op_length;
              mem_read       <= ~d_write;
              mem_write      <= d_write;
            end else begin
              lat_write      <= 1'b0;
              mem_address    <= if_address;
              mem_input_data <= '0;
              mem_op_length  <= OP_WORD;
              mem_read       <= 1'b1;
              mem_write      <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          wait_cnt  <= WAIT_LOAD;
          if (lat_write || READ_LATENCY == 1) begin
            state    <= ST_RESP;
            if_ready <= (owner == OWNER_FETCH);
            d_ready  <= (owner == OWNER_DATA);
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state    <= ST_RESP;
            if_ready <= (owner == OWNER_FETCH);
            d_ready  <= (owner == OWNER_DATA);
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          // Requests are deliberately not sampled here so IDLE lasts a cycle.
          state    <= ST_IDLE;
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign if_data = if_ready ? mem_output_data : '0;
  assign d_rdata = (d_ready && !lat_write) ? mem_output_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level timeline model plus directed cases,
// with a second instance at READ_LATENCY=3 for the wait-state cases.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int RL  = 1;
  localparam int SL  = 4;
  localparam int RL3 = 3;

  logic        clock;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_address;
  logic        if_ready;
  logic [31:0] if_data;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [2:0]  d_op_length;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_input_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_op_length;
  logic [31:0] mem_output_data;
  logic        busy;
  logic        owner;

  logic        x_reset_n;
  logic        x_if_req;
  logic [31:0] x_if_address;
  logic        x_if_ready;
  logic [31:0] x_if_data;
  logic        x_d_req;
  logic        x_d_write;
  logic [31:0] x_d_address;
  logic [31:0] x_d_wdata;
  logic [2:0]  x_d_op_length;
  logic        x_d_ready;
  logic [31:0] x_d_rdata;
  logic [31:0] x_mem_address;
  logic [31:0] x_mem_input_data;
  logic        x_mem_read;
  logic        x_mem_write;
  logic [2:0]  x_mem_op_length;
  logic [31:0] x_mem_output_data;
  logic        x_busy;
  logic        x_owner;

  mem_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_address(if_address), .if_ready(if_ready), .if_data(if_data),
    .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_op_length(d_op_length), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_input_data(mem_input_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_op_length(mem_op_length), .mem_output_data(mem_output_data),
    .busy(busy), .owner(owner)
  );

  mem_arbiter #(.READ_LATENCY(RL3), .STARVE_LIMIT(SL)) dut3 (
    .clock(clock), .reset_n(x_reset_n),
    .if_req(x_if_req), .if_address(x_if_address), .if_ready(x_if_ready), .if_data(x_if_data),
    .d_req(x_d_req), .d_write(x_d_write), .d_address(x_d_address), .d_wdata(x_d_wdata),
    .d_op_length(x_d_op_length), .d_ready(x_d_ready), .d_rdata(x_d_rdata),
    .mem_address(x_mem_address), .mem_input_data(x_mem_input_data), .mem_read(x_mem_read),
    .mem_write(x_mem_write), .mem_op_length(x_mem_op_length), .mem_output_data(x_mem_output_data),
    .busy(x_busy), .owner(x_owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h00A0_0083;
  endfunction

  // Read data appears READ_LATENCY cycles after the cycle mem_read is high.
  logic [31:0] mpipe  [RL];
  logic [31:0] mpipe3 [RL3];
  always @(posedge clock) begin
    mpipe[0] <= mem_read ? mem_f(mem_address) : 32'hBAD0_BAD0;
    for (int i = 1; i < RL; i++) mpipe[i] <= mpipe[i-1];
    mpipe3[0] <= x_mem_read ? mem_f(x_mem_address) : 32'hBAD3_BAD3;
    for (int i = 1; i < RL3; i++) mpipe3[i] <= mpipe3[i-1];
  end
  assign mem_output_data   = mpipe[RL-1];
  assign x_mem_output_data = mpipe3[RL3-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: one outstanding transaction described by its issue and response cycle.
  bit          m_act;
  bit          m_own;
  bit          m_wr;
  int          m_issue;
  int          m_resp;
  int          m_next;
  int          m_starve;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic [2:0]  m_op;
  bit          dut_grants[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit fetch_wins;
    cyc++;
    if (!reset_n) begin
      m_act = 0; m_starve = 0; m_next = 0;
      return;
    end
    if (m_act && cyc > m_resp) m_act = 0;
    if (!m_act && cyc >= m_next && (if_req || d_req)) begin
      fetch_wins = !d_req;
`ifdef ARB_STARVE_GUARD_EN
      if (d_req && if_req && m_starve == SL) fetch_wins = 1;
      if (fetch_wins) m_starve = 0;
      else if (if_req) m_starve++;
`endif
      m_act   = 1;
      m_issue = cyc;
      m_own   = !fetch_wins;
      if (fetch_wins) begin
        m_wr = 0; m_addr = if_address; m_wd = 0; m_op = OP_WORD;
      end else begin
        m_wr = d_write; m_addr = d_address; m_wd = d_wdata; m_op = d_op_length;
      end
      m_resp = cyc + (m_wr ? 1 : RL);
      m_next = m_resp + 2;
    end
  endtask

  task automatic compare();
    bit bz, iss, wt, rsp;
    if (!reset_n) return;
    bz  = m_act && cyc >= m_issue && cyc <= m_resp;
    iss = m_act && cyc == m_issue;
    wt  = m_act && cyc > m_issue && cyc < m_resp;
    rsp = m_act && cyc == m_resp;
    chk("busy", busy, bz);
    chk("mem_read", mem_read, iss && !m_wr);
    chk("mem_write", mem_write, iss && m_wr);
    chk("if_ready", if_ready, rsp && !m_own);
    chk("d_ready", d_ready, rsp && m_own);
    chk("if_data", if_data, (rsp && !m_own) ? mem_f(m_addr) : 32'h0);
    chk("d_rdata", d_rdata, (rsp && m_own && !m_wr) ? mem_f(m_addr) : 32'h0);
    if (bz) chk("owner", owner, m_own);
    if (iss || wt) begin
      chk("mem_address", mem_address, m_addr);
      chk("mem_input_data", mem_input_data, m_wd);
      chk("mem_op_length", mem_op_length, m_op);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
    if (mem_read || mem_write) dut_grants.push_back(owner);
  endtask

  task automatic drive_random();
    if (if_req) begin
      if (if_ready || $urandom_range(0, 15) == 0) if_req = 0;
    end else if ($urandom_range(0, 1) == 1) begin
      if_req     = 1;
      if_address = $urandom & 32'h0000_0FFC;
    end
    if (d_req) begin
      if (d_ready || $urandom_range(0, 15) == 0) d_req = 0;
    end else if ($urandom_range(0, 1) == 1) begin
      d_req       = 1;
      d_write     = 1'($urandom_range(0, 1));
      d_address   = $urandom & 32'h0000_0FFC;
      d_wdata     = $urandom;
      d_op_length = 3'($urandom_range(0, 2));
    end
  endtask

  initial begin
    int pulses;
    int reads;
    bit exp_g;
    reset_n = 0; x_reset_n = 0;
    if_req = 0; if_address = 0; d_req = 0; d_write = 0; d_address = 0; d_wdata = 0; d_op_length = 0;
    x_if_req = 0; x_if_address = 0; x_d_req = 0; x_d_write = 0; x_d_address = 0; x_d_wdata = 0;
    x_d_op_length = 0;
    repeat (3) cycle();

    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst3_busy", x_busy, 0);
    chk("rst3_if_ready", x_if_ready, 0);
    chk("rst3_if_data", x_if_data, 0);
    chk("rst3_d_rdata", x_d_rdata, 0);
    chk("rst3_mem_input_data", x_mem_input_data, 0);
    chk("rst3_mem_write", x_mem_write, 0);
    chk("rst3_mem_op_length", x_mem_op_length, 0);
    chk("rst3_owner", x_owner, 0);
    reset_n = 1; x_reset_n = 1;
    cycle();

    // Fetch of 0x10
    if_req = 1; if_address = 32'h10;
    cycle();
    chk("fetch_issue_read", mem_read, 1);
    chk("fetch_issue_addr", mem_address, 32'h10);
    chk("fetch_issue_op", mem_op_length, OP_WORD);
    chk("fetch_issue_ready", if_ready, 0);
    cycle();
    chk("fetch_ready", if_ready, 1);
    chk("fetch_data", if_data, 32'h00A0_0093);
    if_req = 0;
    cycle();
    chk("fetch_ready_end", if_ready, 0);
    cycle();

    // Store 0xDEADBEEF to 0x40
    d_req = 1; d_write = 1; d_address = 32'h40; d_wdata = 32'hDEAD_BEEF; d_op_length = OP_WORD;
    cycle();
    chk("store_write", mem_write, 1);
    chk("store_read", mem_read, 0);
    chk("store_addr", mem_address, 32'h40);
    chk("store_wdata", mem_input_data, 32'hDEAD_BEEF);
    cycle();
    chk("store_write_end", mem_write, 0);
    chk("store_ready", d_ready, 1);
    chk("store_rdata", d_rdata, 0);
    d_req = 0;
    cycle();
    chk("store_ready_end", d_ready, 0);
    cycle();

    // Load whose request is dropped during ISSUE
    d_req = 1; d_write = 0; d_address = 32'h44; d_op_length = OP_WORD;
    cycle();
    d_req = 0;
    pulses = 0; reads = 0;
    repeat (6) begin
      cycle();
      pulses += int'(d_ready);
      reads  += int'(mem_read);
    end
    chk("drop_ready_pulses", pulses, 1);
    chk("drop_no_new_read", reads, 0);

    repeat (3000) begin
      cycle();
      drive_random();
    end
    if_req = 0; d_req = 0;
    repeat (6) cycle();

    // Asynchronous reset in the middle of a fetch
    if_req = 1; if_address = 32'h20;
    cycle();
    #1 reset_n = 0;
    #1;
    chk("midrst_mem_read", mem_read, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", mem_address, 0);
    chk("midrst_if_ready", if_ready, 0);
    if_req = 0;
    cycle();
    reset_n = 1;
    pulses = 0;
    repeat (5) begin
      cycle();
      pulses += int'(if_ready);
    end
    chk("midrst_no_stale_ready", pulses, 0);

    // Both requesters held continuously from a clean counter
    reset_n = 0;
    cycle();
    reset_n = 1;
    if_req = 1; if_address = 32'h100;
    d_req = 1; d_write = 0; d_address = 32'h200; d_op_length = OP_WORD;
    dut_grants.delete();
    repeat (60) cycle();
    if_req = 0; d_req = 0;
    repeat (6) cycle();
    chk("starve_grant_count_ok", 32'(dut_grants.size() >= 10), 1);
    if (dut_grants.size() >= 10) begin
      for (int i = 0; i < 10; i++) begin
`ifdef ARB_STARVE_GUARD_EN
        exp_g = (i % 5 == 4) ? OWNER_FETCH : OWNER_DATA;
`else
        exp_g = OWNER_DATA;
`endif
        chk($sformatf("starve_grant%0d", i), dut_grants[i], exp_g);
      end
    end

    // READ_LATENCY=3 load of 0x80
    x_d_req = 1; x_d_write = 0; x_d_address = 32'h80; x_d_op_length = OP_WORD;
    cycle();
    chk("rl3_issue_read", x_mem_read, 1);
    chk("rl3_issue_addr", x_mem_address, 32'h80);
    cycle();
    chk("rl3_wait1_read", x_mem_read, 0);
    chk("rl3_wait1_addr", x_mem_address, 32'h80);
    chk("rl3_wait1_busy", x_busy, 1);
    cycle();
    chk("rl3_wait2_read", x_mem_read, 0);
    chk("rl3_wait2_ready", x_d_ready, 0);
    cycle();
    chk("rl3_ready", x_d_ready, 1);
    chk("rl3_rdata", x_d_rdata, 32'h00A0_0003);
    x_d_req = 0;
    cycle();
    chk("rl3_ready_end", x_d_ready, 0);

    // Asynchronous reset during WAIT
    x_d_req = 1; x_d_address = 32'h88;
    cycle();
    cycle();
    #1 x_reset_n = 0;
    #1;
    chk("rl3_rst_busy", x_busy, 0);
    chk("rl3_rst_read", x_mem_read, 0);
    chk("rl3_rst_addr", x_mem_address, 0);
    chk("rl3_rst_ready", x_d_ready, 0);
    x_d_req = 0;
    cycle();
    x_reset_n = 1;
    pulses = 0;
    repeat (6) begin
      cycle();
      pulses += int'(x_d_ready);
    end
    chk("rl3_rst_no_stale_ready", pulses, 0);
    x_d_req = 1; x_d_address = 32'h84;
    cycle();
    chk("rl3_after_rst_read", x_mem_read, 1);
    chk("rl3_after_rst_addr", x_mem_address, 32'h84);
    cycle();
    cycle();
    cycle();
    chk("rl3_after_rst_ready", x_d_ready, 1);
    chk("rl3_after_rst_rdata", x_d_rdata, 32'h00A0_0007);
    x_d_req = 0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 1, memory read latency in cycles (legal 1..4).
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive data grants with fetch pending before fetch is forced (legal 1..15).
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch read request; if_address  in  32  fetch byte address.
REQ-006 if_ready  out  1  fetch completion pulse; if_data  out  32  fetch read data, valid while if_ready=1.
REQ-007 d_req  in  1  data request; d_write  in  1  1=store, 0=load; d_address  in  32; d_wdata  in  32; d_op_length  in  3  access length code.
REQ-008 d_ready  out  1  data completion pulse; d_rdata  out  32  load data, valid while d_ready=1.
REQ-009 mem_address  out  32; mem_input_data  out  32; mem_read  out  1; mem_write  out  1; mem_op_length  out  3  (single-port memory side).
REQ-010 mem_output_data  in  32  memory read data.
REQ-011 busy  out  1  state != IDLE; owner  out  1  0=fetch, 1=data, current transaction owner.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: on edge with any req high, latch winner's address/wdata/write/op_length, set owner, go ISSUE; no req -> stay IDLE.
REQ-014 Arbitration: d_req alone -> data; if_req alone -> fetch; both -> data, unless starvation guard forces fetch (REQ-026).
REQ-015 ISSUE (exactly 1 cycle): mem_address/mem_input_data/mem_op_length driven from latches; mem_read=1 for load/fetch, mem_write=1 for store; fetch drives mem_op_length=word code, mem_input_data=0.
REQ-016 ISSUE -> RESP for store, or for read when READ_LATENCY=1; else ISSUE -> WAIT.
REQ-017 WAIT: mem_read/mem_write=0, mem_address held; counts READ_LATENCY-1 cycles, then RESP.
REQ-018 RESP (exactly 1 cycle): owner's ready=1; owner's data output = mem_output_data for reads, 0 for stores; other port's ready=0, data=0.
REQ-019 RESP -> IDLE unconditionally; requests are not sampled on that edge, so IDLE lasts at least 1 cycle (lets requester drop req after ready).
REQ-020 Latency: read = 2+READ_LATENCY cycles from sampling edge to end of ready pulse; store = 3 cycles; back-to-back throughput one access per 3+READ_LATENCY-1 cycles (reads), 3 cycles (stores).
REQ-021 Requester holds req and fields stable until its ready; request inputs ignored outside IDLE.
REQ-022 req dropped mid-transaction: transaction still completes and ready still pulses.
REQ-023 Outside ISSUE/WAIT mem_read=mem_write=0; outside RESP both ready=0 and both data outputs=0.
REQ-024 Never more than one transaction outstanding; never both readies high.

Reset
REQ-025 reset_n low (asynchronous, including mid-transaction): state=IDLE, owner=0, latches=0, starve counter=0, all outputs 0 immediately; aborted transaction produces no ready.

Configuration
REQ-026 ARB_STARVE_GUARD_EN defined: 4-bit counter increments on each data grant made while if_req high, clears on any fetch grant; when counter==STARVE_LIMIT and both req high, fetch wins and counter clears.
REQ-027 ARB_STARVE_GUARD_EN undefined: strict data priority, no counter logic.

Structure
REQ-028 Shared package/defines: FSM state encoding, owner codes, mem_op_length codes (word code reused by fetch).
REQ-029 One combinational sub-module mem_arbiter_pick (inputs if_req, d_req, starve flag; output winner); FSM and latches stay in mem_arbiter.

Verification
REQ-030 Fetch only, READ_LATENCY=1, if_address=0x10, mem returns 0x00A00093 -> if_ready single pulse 3 cycles after sampling edge, if_data=0x00A00093.
REQ-031 Store d_address=0x40, d_wdata=0xDEADBEEF -> mem_write=1 exactly one cycle with those values, d_ready pulse, d_rdata=0.
REQ-032 Both req held continuously, STARVE_LIMIT=4, guard enabled -> grants D,D,D,D,F repeat; guard disabled -> fetch never granted.
REQ-033 READ_LATENCY=3 load 0x80 -> mem_read one cycle, WAIT 2 cycles, d_ready in 5th cycle after sampling edge with memory data.
REQ-034 reset_n low during WAIT -> mem_read/busy/ready 0 immediately; after release, next request served normally with no stale ready.
REQ-035 d_req dropped during ISSUE -> d_ready still pulses once; no second transaction started.
